jpeg_ycc_block_front: RTL and testbench



---
 rtl/jpeg_pkg.sv | 26 ++
 rtl/rgb_to_ycc_conv.sv | 59 +++++
 rtl/jpeg_ycc_block_front.sv | 84 ++++++++
 tb/tb_jpeg_ycc_block_front.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG encoder front end:
// sample type, block size and the fixed-point RGB -> YCbCr coefficients.
package jpeg_pkg;

    localparam int DATA_W    = 12;
    localparam int BLOCK_PIX = 64;
    localparam int MAC_W     = 20;
    localparam int RND_SHIFT = 8;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Coefficients are 8.8 fixed point. The subtracted terms are stored as magnitudes.
    localparam logic signed [MAC_W-1:0] C_Y_R  = 20'sd77;
    localparam logic signed [MAC_W-1:0] C_Y_G  = 20'sd150;
    localparam logic signed [MAC_W-1:0] C_Y_B  = 20'sd29;
    localparam logic signed [MAC_W-1:0] C_CB_R = 20'sd43;
    localparam logic signed [MAC_W-1:0] C_CB_G = 20'sd85;
    localparam logic signed [MAC_W-1:0] C_CB_B = 20'sd128;
    localparam logic signed [MAC_W-1:0] C_CR_R = 20'sd128;
    localparam logic signed [MAC_W-1:0] C_CR_G = 20'sd107;
    localparam logic signed [MAC_W-1:0] C_CR_B = 20'sd21;

    localparam logic signed [MAC_W-1:0] C_ROUND       = 20'sd128;
    localparam logic signed [MAC_W-1:0] C_LEVEL_SHIFT = 20'sd128;

endpackage

// File: rtl/rgb_to_ycc_conv.sv
// Registered RGB -> level-shifted YCbCr converter with a one-cycle valid pipeline.
// The data registers load only on a valid input and otherwise hold.
module rgb_to_ycc_conv
    import jpeg_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_valid,
    input  logic [7:0]        i_red,
    input  logic [7:0]        i_green,
    input  logic [7:0]        i_blue,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_y,
    output logic [DATA_W-1:0] o_cb,
    output logic [DATA_W-1:0] o_cr
);

    logic signed [MAC_W-1:0] w_r, w_g, w_b;
    logic signed [MAC_W-1:0] w_y_sum, w_cb_sum, w_cr_sum;
    logic signed [MAC_W-1:0] w_y_res, w_cb_res, w_cr_res;

    logic    r_valid;
    sample_t r_y, r_cb, r_cr;

    assign w_r = $signed({{(MAC_W-8){1'b0}}, i_red});
    assign w_g = $signed({{(MAC_W-8){1'b0}}, i_green});
    assign w_b = $signed({{(MAC_W-8){1'b0}}, i_blue});

    assign w_y_sum  = C_Y_R * w_r + C_Y_G * w_g + C_Y_B * w_b + C_ROUND;
    assign w_cb_sum = C_ROUND - C_CB_R * w_r - C_CB_G * w_g + C_CB_B * w_b;
    assign w_cr_sum = C_ROUND + C_CR_R * w_r - C_CR_G * w_g - C_CR_B * w_b;

    // Arithmetic shift floors negative sums; results always fit the 12-bit sample.
    assign w_y_res  = (w_y_sum >>> RND_SHIFT) - C_LEVEL_SHIFT;
    assign w_cb_res = w_cb_sum >>> RND_SHIFT;
    assign w_cr_res = w_cr_sum >>> RND_SHIFT;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_cb    <= '0;
            r_cr    <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_y  <= DATA_W'(w_y_res);
                r_cb <= DATA_W'(w_cb_res);
                r_cr <= DATA_W'(w_cr_res);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_y     = r_y;
    assign o_cb    = r_cb;
    assign o_cr    = r_cr;

endmodule

// File: rtl/jpeg_ycc_block_front.sv
// JPEG encoder front end: converts RGB pixels to YCbCr and collects one 8x8
// block per component, then holds it until the consumer acknowledges.
module jpeg_ycc_block_front
    import jpeg_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              input_1pix_enable,
    input  logic [7:0]        red,
    input  logic [7:0]        green,
    input  logic [7:0]        blue,
    input  logic              block_ack,
    output logic [DATA_W-1:0] y_data,
    output logic [DATA_W-1:0] cb_data,
    output logic [DATA_W-1:0] cr_data,
    output logic              data_valid,
    input  logic [5:0]        rd_addr,
    output logic [DATA_W-1:0] rd_y,
    output logic [DATA_W-1:0] rd_cb,
    output logic [DATA_W-1:0] rd_cr,
    output logic              block_ready,
    output logic [6:0]        wr_count
);

    logic w_accept;
    logic w_wr_en;

    logic       r_block_ready;
    logic [6:0] r_wr_count;

    sample_t r_buf_y  [BLOCK_PIX];
    sample_t r_buf_cb [BLOCK_PIX];
    sample_t r_buf_cr [BLOCK_PIX];

    assign w_accept = input_1pix_enable & ~r_block_ready;

    rgb_to_ycc_conv u_conv (
        .clock   (clock),
        .reset_n (reset_n),
        .i_valid (w_accept),
        .i_red   (red),
        .i_green (green),
        .i_blue  (blue),
        .o_valid (data_valid),
        .o_y     (y_data),
        .o_cb    (cb_data),
        .o_cr    (cr_data)
    );

    // A sample still in flight when the block completes must not wrap onto index 0.
    assign w_wr_en = data_valid & ~r_block_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_count    <= '0;
            r_block_ready <= 1'b0;
        end else if (r_block_ready) begin
            if (block_ack) begin
                r_wr_count    <= '0;
                r_block_ready <= 1'b0;
            end
        end else if (w_wr_en) begin
            r_wr_count <= r_wr_count + 7'd1;
            if (r_wr_count == 7'(BLOCK_PIX - 1)) begin
                r_block_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_buf_y[r_wr_count[5:0]]  <= sample_t'(y_data);
            r_buf_cb[r_wr_count[5:0]] <= sample_t'(cb_data);
            r_buf_cr[r_wr_count[5:0]] <= sample_t'(cr_data);
        end
    end

    assign rd_y        = r_buf_y[rd_addr];
    assign rd_cb       = r_buf_cb[rd_addr];
    assign rd_cr       = r_buf_cr[rd_addr];
    assign block_ready = r_block_ready;
    assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_jpeg_ycc_block_front.sv
// Bench for jpeg_ycc_block_front: randomized pixels and acks checked every
// cycle against an arithmetic model of conversion, block fill and acknowledge.
module tb_jpeg_ycc_block_front;

    logic        clock;
    logic        reset_n;
    logic        input_1pix_enable;
    logic [7:0]  red, green, blue;
    logic        block_ack;
    logic [11:0] y_data, cb_data, cr_data;
    logic        data_valid;
    logic [5:0]  rd_addr;
    logic [11:0] rd_y, rd_cb, rd_cr;
    logic        block_ready;
    logic [6:0]  wr_count;

    jpeg_ycc_block_front dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .input_1pix_enable (input_1pix_enable),
        .red               (red),
        .green             (green),
        .blue              (blue),
        .block_ack         (block_ack),
        .y_data            (y_data),
        .cb_data           (cb_data),
        .cr_data           (cr_data),
        .data_valid        (data_valid),
        .rd_addr           (rd_addr),
        .rd_y              (rd_y),
        .rd_cb             (rd_cb),
        .rd_cr             (rd_cr),
        .block_ready       (block_ready),
        .wr_count          (wr_count)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #100 clock = ~clock;
    end

    // Scoreboard state
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [35:0] exp_q[$];
    bit          m_ready;
    int          m_count;
    bit          m_pend;
    int          m_py, m_pcb, m_pcr;
    int          m_buf_y  [64];
    int          m_buf_cb [64];
    int          m_buf_cr [64];

    function automatic int ref_y(int r, int g, int b);
        return ((77 * r + 150 * g + 29 * b + 128) >>> 8) - 128;
    endfunction

    function automatic int ref_cb(int r, int g, int b);
        return (-43 * r - 85 * g + 128 * b + 128) >>> 8;
    endfunction

    function automatic int ref_cr(int r, int g, int b);
        return (128 * r - 107 * g - 21 * b + 128) >>> 8;
    endfunction

    function automatic logic [11:0] to12(int v);
        return 12'(v);
    endfunction

    task automatic check(input string tag, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Driver: one clock cycle of stimulus, model update and output checks.
    task automatic cycle(input bit en, input int r, input int g, input int b, input bit ack);
        bit acc;
        logic [35:0] e;
        @(negedge clock);
        input_1pix_enable = en;
        red   = 8'(r);
        green = 8'(g);
        blue  = 8'(b);
        block_ack = ack;
        acc = en && !m_ready;
        if (m_ready) begin
            if (ack) begin
                m_ready = 1'b0;
                m_count = 0;
            end
        end else if (m_pend) begin
            m_buf_y[m_count]  = m_py;
            m_buf_cb[m_count] = m_pcb;
            m_buf_cr[m_count] = m_pcr;
            m_count++;
            if (m_count == 64) m_ready = 1'b1;
        end
        m_pend = acc;
        if (acc) begin
            m_py  = ref_y(r, g, b);
            m_pcb = ref_cb(r, g, b);
            m_pcr = ref_cr(r, g, b);
            exp_q.push_back({to12(m_py), to12(m_pcb), to12(m_pcr)});
        end
        @(posedge clock);
        #1;
        check("data_valid", 36'(data_valid), 36'(m_pend));
        if (m_pend && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("y_data",  36'(y_data),  36'(e[35:24]));
            check("cb_data", 36'(cb_data), 36'(e[23:12]));
            check("cr_data", 36'(cr_data), 36'(e[11:0]));
        end
        check("wr_count",    36'(wr_count),    36'(m_count));
        check("block_ready", 36'(block_ready), 36'(m_ready));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        input_1pix_enable = 1'b0;
        block_ack = 1'b0;
        @(posedge clock);
        #1;
        m_ready = 1'b0;
        m_count = 0;
        m_pend  = 1'b0;
        exp_q.delete();
        check("rst_y",           36'(y_data),      36'(0));
        check("rst_cb",          36'(cb_data),     36'(0));
        check("rst_cr",          36'(cr_data),     36'(0));
        check("rst_data_valid",  36'(data_valid),  36'(0));
        check("rst_block_ready", 36'(block_ready), 36'(0));
        check("rst_wr_count",    36'(wr_count),    36'(0));
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Reads every written index; done right after an edge, well inside the half period.
    task automatic check_reads();
        for (int a = 0; a < m_count; a++) begin
            rd_addr = 6'(a);
            #1;
            check("rd_y",  36'(rd_y),  36'(to12(m_buf_y[a])));
            check("rd_cb", 36'(rd_cb), 36'(to12(m_buf_cb[a])));
            check("rd_cr", 36'(rd_cr), 36'(to12(m_buf_cr[a])));
        end
    endtask

    task automatic rand_pixel(input bit ack);
        cycle(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), ack);
    endtask

    initial begin
        reset_n = 1'b1;
        input_1pix_enable = 1'b0;
        red = 8'd0;
        green = 8'd0;
        blue = 8'd0;
        block_ack = 1'b0;
        rd_addr = 6'd0;
        m_ready = 1'b0;
        m_count = 0;
        m_pend  = 1'b0;

        do_reset();

        // Corner colours against hand-derived values
        cycle(1'b1, 0, 0, 0, 1'b0);
        check("black_y", 36'(y_data), 36'(to12(-128)));
        cycle(1'b1, 255, 255, 255, 1'b0);
        check("white_y",  36'(y_data),  36'(to12(127)));
        check("white_cb", 36'(cb_data), 36'(to12(0)));
        cycle(1'b1, 255, 0, 0, 1'b0);
        check("red_y",  36'(y_data),  36'(to12(-51)));
        check("red_cb", 36'(cb_data), 36'(to12(-43)));
        check("red_cr", 36'(cr_data), 36'(to12(128)));
        cycle(1'b1, 0, 0, 255, 1'b0);
        check("blue_y",  36'(y_data),  36'(to12(-99)));
        check("blue_cb", 36'(cb_data), 36'(to12(128)));
        check("blue_cr", 36'(cr_data), 36'(to12(-21)));
        cycle(1'b0, 0, 0, 0, 1'b0);
        check("hold_y", 36'(y_data), 36'(to12(-99)));
        check_reads();

        // Full block with R = index
        do_reset();
        for (int i = 0; i < 64; i++) cycle(1'b1, i, 0, 0, 1'b0);
        cycle(1'b0, 0, 0, 0, 1'b0);
        check("full_ready", 36'(block_ready), 36'(1));
        check("full_count", 36'(wr_count),    36'(64));
        rd_addr = 6'd10;
        #1;
        check("rd_y_idx10", 36'(rd_y), 36'(to12(-125)));
        check_reads();

        // Pixels while the block is held are dropped
        for (int i = 0; i < 5; i++) rand_pixel(1'b0);
        check_reads();
        cycle(1'b0, 0, 0, 0, 1'b1);
        check("ack_count", 36'(wr_count), 36'(0));
        rand_pixel(1'b0);
        cycle(1'b0, 0, 0, 0, 1'b0);
        check_reads();

        // Ack and pixel in the same cycle: the pixel is dropped
        for (int i = 0; i < 63; i++) rand_pixel(1'b0);
        cycle(1'b0, 0, 0, 0, 1'b0);
        rand_pixel(1'b1);
        check("ack_drop_valid", 36'(data_valid), 36'(0));
        cycle(1'b0, 0, 0, 0, 1'b0);
        check("ack_drop_count", 36'(wr_count), 36'(0));

        // Reset in the middle of a block discards it
        for (int i = 0; i < 30; i++) rand_pixel(1'b0);
        do_reset();
        for (int i = 0; i < 64; i++) rand_pixel(1'b0);
        check("post_rst_not_ready", 36'(block_ready), 36'(0));
        cycle(1'b0, 0, 0, 0, 1'b0);
        check("post_rst_ready", 36'(block_ready), 36'(1));
        check_reads();

        // Random enable gaps and acks
        for (int i = 0; i < 300; i++) begin
            bit en;
            bit ack;
            en  = ($urandom_range(0, 3) != 0) && !(m_pend && m_count == 63);
            ack = m_ready && ($urandom_range(0, 3) == 0);
            cycle(en, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), ack);
            if (m_ready && $urandom_range(0, 7) == 0) check_reads();
        end
        cycle(1'b0, 0, 0, 0, 1'b0);
        check_reads();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
